// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if -- request/result bundle for the sequential multiplier.
//   START  : request to begin a multiply (sampled on CLK rising edge)
//   SIGNED : 1 = two's-complement operands, 0 = unsigned (sampled with START)
//   A, B   : multiplicand / multiplier, WIDTH bits (sampled with START)
//   P      : 2*WIDTH-bit product, valid from the DONE cycle until the next DONE
//   BUSY   : high while an operation is in progress
//   DONE   : one-cycle pulse marking P valid
// master = requester side, slave = multiplier side.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 START;
  logic                 SIGNED;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2*WIDTH-1:0]   P;
  logic                 BUSY;
  logic                 DONE;

  modport master (
    output START, SIGNED, A, B,
    input  P, BUSY, DONE
  );

  modport slave (
    input  START, SIGNED, A, B,
    output P, BUSY, DONE
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl -- radix-2 shift-add sequential multiplier, signed or unsigned.
// Operands are reduced to magnitudes at capture, multiplied unsigned over WIDTH
// cycles, and the sign is applied in one final cycle. Latency is fixed at
// WIDTH+2 edges from the START edge to the DONE cycle.
// Ports:
//   CLK   : single clock, rising edge
//   RESET : synchronous, active-high; aborts any operation, clears P
//   bus   : mult_seq_ctrl_if.slave (START, SIGNED, A, B in; P, BUSY, DONE out)
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  mult_seq_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int ACC_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       sum_w;
  logic [2*WIDTH-1:0]   fin_w;

  // Unsigned magnitude of an operand. The most negative value maps onto
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH-1:0] r;
    r = v;
    if (is_signed && v < 0)
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b1}} & '0, 1'b1};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    p_d     = p_q;
    done_d  = 1'b0;
    // Upper half plus multiplicand, carry kept in the extra accumulator bit.
    sum_w   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    fin_w   = neg_q ? negate(acc_q[2*WIDTH-1:0]) : acc_q[2*WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          mcand_d = magnitude(bus.A, bus.SIGNED);
          // Multiplier magnitude sits in the low half and is consumed LSB first.
          acc_d   = {{(WIDTH+1){1'b0}}, magnitude(bus.B, bus.SIGNED)};
          neg_d   = bus.SIGNED & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (acc_q[0])
          acc_d = {sum_w, acc_q[WIDTH-1:0]} >> 1;
        else
          acc_d = acc_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1))
          state_d = SIGN;
      end
      SIGN: begin
        acc_d   = {1'b0, fin_w};
        p_d     = fin_w;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  // Multiplicand is only read in CALC, which is always preceded by a capture.
  always_ff @(posedge CLK) begin
    mcand_q <= mcand_d;
  end

  assign bus.P    = p_q;
  assign bus.BUSY = (state_q != IDLE);
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RESET;

  mult_seq_ctrl_if #(.WIDTH(W)) bus();

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2*W-1:0] p_prev;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  vec_t vecs[8];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: exact product using native 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Issue one START pulse and wait for DONE (bounded). poke_cyc >= 1 injects,
  // at that cycle, either a RESET pulse (poke_rst) or a START pulse with 9x9.
  // lat = edges from the START edge up to the DONE cycle (80 = no DONE seen).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int poke_cyc, input bit poke_rst,
                        output logic [2*W-1:0] p_out, output int lat);
    bit quiet_ok;
    quiet_ok   = 1'b1;
    bus.START  = 1'b1;
    bus.A      = a;
    bus.B      = b;
    bus.SIGNED = s;
    tick();
    lat        = 1;
    bus.START  = 1'b0;
    bus.A      = $urandom;
    bus.B      = $urandom;
    bus.SIGNED = ~s;
    if (bus.DONE !== 1'b1)
      quiet_ok &= (bus.BUSY === 1'b1) && (bus.P === p_prev);
    while (bus.DONE !== 1'b1 && lat < 80) begin
      if (lat == poke_cyc) begin
        if (poke_rst) RESET = 1'b1;
        else begin
          bus.START = 1'b1;
          bus.A     = 9;
          bus.B     = 9;
        end
      end
      tick();
      lat++;
      if (lat == poke_cyc + 1) begin
        RESET     = 1'b0;
        bus.START = 1'b0;
        if (poke_rst) begin
          check64("reset_busy", bus.BUSY, 0);
          check64("reset_done", bus.DONE, 0);
          check64("reset_p", bus.P, 0);
          p_prev = '0;
        end
      end
      if (bus.DONE !== 1'b1) begin
        if (poke_rst && poke_cyc > 0 && lat > poke_cyc)
          quiet_ok &= (bus.BUSY === 1'b0) && (bus.P === '0);
        else
          quiet_ok &= (bus.BUSY === 1'b1) && (bus.P === p_prev);
      end
    end
    check64("busy_and_p_hold_while_running", quiet_ok, 1);
    p_out = bus.P;
    if (bus.DONE === 1'b1) begin
      check64("busy_low_at_done", bus.BUSY, 0);
      p_prev = bus.P;
      tick();
      check64("done_single_cycle", bus.DONE, 0);
      check64("p_held_after_done", bus.P, p_prev);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2*W-1:0] p;
    int lat, t, t1, t2, dcount;
    logic [W-1:0] ra, rb;
    logic rs;

    vecs[0] = '{32'd3,         32'd5,         1'b0, 64'h000000000000000F, "u_3x5"};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 64'hFFFFFFFE00000001, "u_max_sq"};
    vecs[2] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 64'h0000000000000001, "s_m1_sq"};
    vecs[3] = '{32'hFFFFFFF9,  32'd3,         1'b1, 64'hFFFFFFFFFFFFFFEB, "s_m7x3"};
    vecs[4] = '{32'h80000000,  32'h80000000,  1'b1, 64'h4000000000000000, "s_min_sq"};
    vecs[5] = '{32'h7FFFFFFF,  32'h80000000,  1'b1, 64'hC000000080000000, "s_max_x_min"};
    vecs[6] = '{32'd0,         32'hFFFFFFFF,  1'b1, 64'h0000000000000000, "s_zero"};
    vecs[7] = '{32'hFFFFFFFF,  32'd1,         1'b0, 64'h00000000FFFFFFFF, "u_max_x1"};

    // Reset with START held high: START must be ignored.
    RESET      = 1'b1;
    bus.START  = 1'b1;
    bus.A      = 3;
    bus.B      = 5;
    bus.SIGNED = 1'b0;
    tick();
    tick();
    check64("rst_busy", bus.BUSY, 0);
    check64("rst_done", bus.DONE, 0);
    check64("rst_p", bus.P, 0);
    RESET     = 1'b0;
    bus.START = 1'b0;
    tick();
    check64("idle_busy", bus.BUSY, 0);
    p_prev = '0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, -1, 1'b0, p, lat);
      check64({vecs[i].name, "_p"}, p, vecs[i].exp);
      check64({vecs[i].name, "_latency"}, 64'(lat), 64'(W + 2));
    end

    // START re-pulsed mid-operation with 9x9 is ignored.
    run_op(32'd3, 32'd5, 1'b0, 10, 1'b0, p, lat);
    check64("repulse_p", p, 64'd15);
    check64("repulse_latency", 64'(lat), 64'(W + 2));
    dcount = 0;
    for (int i = 0; i < W + 8; i++) begin
      tick();
      if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) dcount++;
    end
    check64("repulse_no_second_op", 64'(dcount), 0);

    // Reset at cycle 20 aborts without DONE; then 2x2.
    run_op(32'd3, 32'd5, 1'b0, 20, 1'b1, p, lat);
    check64("abort_no_done", 64'(lat), 64'd80);
    run_op(32'd2, 32'd2, 1'b0, -1, 1'b0, p, lat);
    check64("after_abort_p", p, 64'd4);
    check64("after_abort_latency", 64'(lat), 64'(W + 2));

    // START held high: 1x1 then 2x3 back to back.
    bus.START  = 1'b1;
    bus.A      = 1;
    bus.B      = 1;
    bus.SIGNED = 1'b0;
    tick();
    t = 1;
    bus.A = 2;
    bus.B = 3;
    while (bus.DONE !== 1'b1 && t < 80) begin tick(); t++; end
    t1 = t;
    check64("held_first_p", bus.P, 64'd1);
    check64("held_first_latency", 64'(t1), 64'(W + 2));
    tick();
    t++;
    while (bus.DONE !== 1'b1 && t < 200) begin tick(); t++; end
    t2 = t;
    bus.START = 1'b0;
    check64("held_second_p", bus.P, 64'd6);
    check64("held_spacing", 64'(t2 - t1), 64'(W + 2));
    p_prev = bus.P;
    tick();
    check64("held_done_single", bus.DONE, 0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) ra = 32'h80000000;
      if (i % 8 == 1) rb = 32'hFFFFFFFF;
      run_op(ra, rb, rs, -1, 1'b0, p, lat);
      check64("rand_p", p, ref_mul(ra, rb, rs));
      check64("rand_latency", 64'(lat), 64'(W + 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
